// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath: accumulator width, ceil-log2 and saturation.
// Used by the DSP-cascade PE, the feature-map streamer and the output collector.
package conv_pkg;

  localparam int unsigned PE_P_W = 48;

  // One guard bit above the PE sum so rounding can never wrap.
  typedef logic signed [PE_P_W:0] acc_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

  // Clamp to the signed range of an out_w-bit number; result keeps the wide type.
  function automatic acc_t saturate(input acc_t v, input int unsigned out_w);
    acc_t one, max_v, min_v;
    one   = acc_t'(1);
    max_v = (one <<< (out_w - 1)) - one;
    min_v = -max_v - one;
    if (v > max_v) return max_v;
    if (v < min_v) return min_v;
    return v;
  endfunction

endpackage

// File: rtl/conv_out_fifo.sv
// Synchronous first-word-fall-through FIFO: head entry is visible on rdata_o whenever !empty_o.
// A push while full is accepted only if a pop happens in the same cycle.
module conv_out_fifo
  import conv_pkg::*;
#(
  parameter int unsigned Width = 17,
  parameter int unsigned Depth = 16,
  localparam int unsigned AddrW = clog2(Depth),
  localparam int unsigned CntW  = clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  always_comb begin
    full_o  = (count_q == CntW'(Depth));
    empty_o = (count_q == '0);
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    rdata_o = mem_q[rd_ptr_q];
    count_o = count_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/conv_out_collector.sv
// Collects the free-running PE sum stream, keeps only valid strided windows, requantizes and
// queues them for the OFM writer. Define CONV_COLLECT_RELU_EN to fuse a ReLU after saturation.
module conv_out_collector
  import conv_pkg::*;
#(
  parameter int unsigned KERNEL_SIZE = 2,
  parameter int unsigned IMG_W       = 8,
  parameter int unsigned IMG_H       = 8,
  parameter int unsigned STRIDE      = 1,
  parameter int unsigned PE_LAT      = 3,
  parameter int unsigned SHIFT       = 8,
  parameter int unsigned OUT_W       = 16,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_pix_valid,
  input  logic signed [PE_P_W-1:0] i_P,
  output logic [OUT_W-1:0]         o_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_last,
  output logic                     o_frame_done,
  output logic                     o_overflow,
  output logic                     o_almost_full
);

  localparam int unsigned ColW    = clog2(IMG_W + 1);
  localparam int unsigned RowW    = clog2(IMG_H + 1);
  localparam int unsigned PhW     = clog2(STRIDE + 1);
  localparam int unsigned CntW    = clog2(FIFO_DEPTH + 1);
  localparam int unsigned LastCol = IMG_W - 1 - ((IMG_W - KERNEL_SIZE) % STRIDE);
  localparam int unsigned LastRow = IMG_H - 1 - ((IMG_H - KERNEL_SIZE) % STRIDE);
  localparam acc_t        Round   = (acc_t'(1) <<< SHIFT) >> 1;

  logic [ColW-1:0]   col_q, col_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [PhW-1:0]    cph_q, cph_d, rph_q, rph_d;
  logic              keep, last;
  logic [PE_LAT-1:0] keep_dly_q, last_dly_q;

  acc_t              rounded, shifted;
  logic [OUT_W-1:0]  rq_data;
  logic [OUT_W-1:0]  rq_data_q, hold_q;
  logic              rq_push_q, rq_last_q;
  logic              overflow_q, frame_done_q;

  logic [OUT_W:0]    fifo_rdata;
  logic              fifo_full, fifo_empty, pop;
  logic [CntW-1:0]   fifo_count;

  // Phase counters track (pos-(K-1)) % STRIDE; they sit at 0 up to and including pos K-1.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    cph_d = cph_q;
    rph_d = rph_q;
    if (i_pix_valid) begin
      if (col_q == ColW'(IMG_W - 1)) begin
        col_d = '0;
        cph_d = '0;
        row_d = (row_q == RowW'(IMG_H - 1)) ? '0 : row_q + 1'b1;
        if (row_d <= RowW'(KERNEL_SIZE - 1)) rph_d = '0;
        else rph_d = (rph_q == PhW'(STRIDE - 1)) ? '0 : rph_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
        if (col_d <= ColW'(KERNEL_SIZE - 1)) cph_d = '0;
        else cph_d = (cph_q == PhW'(STRIDE - 1)) ? '0 : cph_q + 1'b1;
      end
    end
  end

  always_comb begin
    keep = i_pix_valid && (col_q >= ColW'(KERNEL_SIZE - 1)) && (row_q >= RowW'(KERNEL_SIZE - 1))
           && (cph_q == '0) && (rph_q == '0);
    last = keep && (col_q == ColW'(LastCol)) && (row_q == RowW'(LastRow));
  end

  // Round half up, arithmetic shift, clamp to OUT_W signed.
  always_comb begin
    rounded = acc_t'(i_P) + Round;
    shifted = rounded >>> SHIFT;
    rq_data = OUT_W'(saturate(shifted, OUT_W));
`ifdef CONV_COLLECT_RELU_EN
    if (rq_data[OUT_W-1]) rq_data = '0;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      col_q        <= '0;
      row_q        <= '0;
      cph_q        <= '0;
      rph_q        <= '0;
      keep_dly_q   <= '0;
      last_dly_q   <= '0;
      rq_push_q    <= 1'b0;
      rq_last_q    <= 1'b0;
      rq_data_q    <= '0;
      hold_q       <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      cph_q <= cph_d;
      rph_q <= rph_d;
      keep_dly_q[0] <= keep;
      last_dly_q[0] <= last;
      for (int i = 1; i < PE_LAT; i++) begin
        keep_dly_q[i] <= keep_dly_q[i-1];
        last_dly_q[i] <= last_dly_q[i-1];
      end
      rq_push_q <= keep_dly_q[PE_LAT-1];
      rq_last_q <= last_dly_q[PE_LAT-1];
      rq_data_q <= rq_data;
      if (pop) hold_q <= fifo_rdata[OUT_W-1:0];
      if (rq_push_q && fifo_full && !pop) overflow_q <= 1'b1;
      frame_done_q <= pop && fifo_rdata[OUT_W];
    end
  end

  conv_out_fifo #(
    .Width (OUT_W + 1),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .push_i  (rq_push_q),
    .wdata_i ({rq_last_q, rq_data_q}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    o_valid       = !fifo_empty;
    pop           = o_valid && i_ready;
    o_data        = fifo_empty ? hold_q : fifo_rdata[OUT_W-1:0];
    o_last        = !fifo_empty && fifo_rdata[OUT_W];
    o_frame_done  = frame_done_q;
    o_overflow    = overflow_q;
    o_almost_full = (fifo_count >= CntW'(FIFO_DEPTH - 2));
  end

endmodule

// File: tb/tb_conv_out_collector.sv
// Scoreboard bench for conv_out_collector (K=3, 8x8, stride 2, SHIFT=8) with a delay-line PE stand-in.
module tb_conv_out_collector;

  localparam int K     = 3;
  localparam int W     = 8;
  localparam int H     = 8;
  localparam int S     = 2;
  localparam int LAT   = 3;
  localparam int SH    = 8;
  localparam int OW    = 16;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic [OW-1:0] data;
    logic          last;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst, pix_valid, ready;
  logic signed [47:0] p;
  logic [OW-1:0]      data;
  logic               valid, last, frame_done, overflow, almost_full;

  always #5 clk = ~clk;

  conv_out_collector #(
    .KERNEL_SIZE (K),
    .IMG_W       (W),
    .IMG_H       (H),
    .STRIDE      (S),
    .PE_LAT      (LAT),
    .SHIFT       (SH),
    .OUT_W       (OW),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_pix_valid   (pix_valid),
    .i_P           (p),
    .o_data        (data),
    .o_valid       (valid),
    .i_ready       (ready),
    .o_last        (last),
    .o_frame_done  (frame_done),
    .o_overflow    (overflow),
    .o_almost_full (almost_full)
  );

  // PE stand-in: the sum for a pixel shows up on i_P LAT cycles later
  longint             pix_val;
  logic signed [47:0] pe_pipe [LAT];
  always @(posedge clk) begin
    pe_pipe[0] <= 48'(pix_val);
    for (int i = 1; i < LAT; i++) pe_pipe[i] <= pe_pipe[i-1];
  end
  assign p = pe_pipe[LAT-1];

  exp_t          sb[$];
  int            n_checks = 0, n_fail = 0;
  int            m_col = 0, m_row = 0;
  int            n_last_exp = 0, n_fd_seen = 0;
  int            ready_mode = 1;
  bit            hold_mode = 0, exp_ovf = 0;
  int            spec_idx = 4;
  longint        spec_in [4];
  logic [OW-1:0] spec_out [4];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] model_requant(input longint v);
    longint r;
    r = (v + ((longint'(1) << SH) >> 1)) >>> SH;
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
`ifdef CONV_COLLECT_RELU_EN
    if (r < 0) r = 0;
`endif
    return r[OW-1:0];
  endfunction

  function automatic longint rand_val();
    longint v;
    v = longint'($signed($urandom));
    return v >>> $urandom_range(4, 20);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       ready = 1'b0;
      1:       ready = 1'b1;
      default: ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic drive(input bit v_in, input longint v);
    bit     keep, lst;
    exp_t   e;
    longint val;
    step();
    val  = v;
    keep = v_in && m_col >= K - 1 && m_row >= K - 1 &&
           (m_col - (K - 1)) % S == 0 && (m_row - (K - 1)) % S == 0;
    lst  = keep && m_col == W - 1 - ((W - K) % S) && m_row == H - 1 - ((H - K) % S);
    if (keep && spec_idx < 4) begin
      val    = spec_in[spec_idx];
      e.data = spec_out[spec_idx];
      spec_idx++;
    end else begin
      e.data = model_requant(val);
    end
    e.last    = lst;
    pix_val   = val;
    pix_valid = v_in;
    if (keep) begin
      if (hold_mode && sb.size() >= DEPTH) exp_ovf = 1'b1;
      else begin
        sb.push_back(e);
        if (lst) n_last_exp++;
      end
    end
    if (v_in) begin
      if (m_col == W - 1) begin
        m_col = 0;
        m_row = (m_row == H - 1) ? 0 : m_row + 1;
      end else m_col++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, rand_val());
  endtask

  task automatic drive_frame(input int gap_pct);
    for (int i = 0; i < W * H; i++) begin
      if ($urandom_range(0, 99) < gap_pct) drive(1'b0, rand_val());
      drive(1'b1, rand_val());
    end
  endtask

  task automatic drain();
    int budget;
    idle(LAT + 3);
    budget = 0;
    while (sb.size() != 0 && budget < 2000) begin
      idle(1);
      budget++;
    end
    idle(2);
    check("drain_left", sb.size(), 0);
  endtask

  // Output monitor: samples on the falling edge, away from the handshake edge
  logic [OW-1:0] prev_data;
  bit            prev_stall = 0, fd_due = 0;
  exp_t          got_e;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
      fd_due     = 0;
    end else begin
      if (frame_done || fd_due) begin
        check("frame_done", frame_done, fd_due);
        if (frame_done) n_fd_seen++;
      end
      fd_due = 0;
      if (prev_stall && valid) check("hold_data", data, prev_data);
      if (valid && ready) begin
        if (sb.size() == 0) check("spurious_valid", valid, 1'b0);
        else begin
          got_e = sb.pop_front();
          check("data", data, got_e.data);
          check("last", last, got_e.last);
          fd_due = got_e.last;
        end
      end
      prev_stall = valid && !ready;
      prev_data  = data;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    spec_in[0]  = 64'h17F;
    spec_in[1]  = 64'h180;
    spec_in[2]  = longint'(1) << 30;
    spec_in[3]  = -(longint'(1) << 30);
    spec_out[0] = 16'h0001;
    spec_out[1] = 16'h0002;
    spec_out[2] = 16'h7FFF;
`ifdef CONV_COLLECT_RELU_EN
    spec_out[3] = 16'h0000;
`else
    spec_out[3] = 16'h8000;
`endif

    rst = 1'b1; pix_valid = 1'b0; pix_val = 0; ready = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid", valid, 1'b0);
    check("rst_data", data, '0);
    check("rst_last", last, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_almost_full", almost_full, 1'b0);

    // Requant corner values, then back-to-back frames under random backpressure
    spec_idx   = 0;
    ready_mode = 1;
    drive_frame(0);
    ready_mode = 2;
    drive_frame(0);
    drive_frame(20);
    drive_frame(0);
    drain();
    check("frames_done_a", n_fd_seen, n_last_exp);
    check("overflow_idle", overflow, 1'b0);

    // Two frames with no ready: 18 windows into 16 slots
    ready_mode = 0;
    hold_mode  = 1;
    drive_frame(0);
    drive_frame(0);
    idle(LAT + 4);
    @(negedge clk);
    check("full_overflow", overflow, exp_ovf);
    check("full_almost_full", almost_full, 1'b1);
    check("full_valid", valid, 1'b1);
    hold_mode  = 0;
    ready_mode = 1;
    drain();
    @(negedge clk);
    check("drained_valid", valid, 1'b0);
    check("frames_done_b", n_fd_seen, n_last_exp);

    // Mid-frame reset with 5 queued samples
    ready_mode = 0;
    for (int i = 0; i < 4 * W + 5; i++) drive(1'b1, rand_val());
    idle(LAT + 4);
    @(negedge clk);
    check("pre_rst_valid", valid, 1'b1);
    check("pre_rst_almost_full", almost_full, 1'b0);
    step();
    rst = 1'b1;
    sb.delete();
    m_col = 0;
    m_row = 0;
    exp_ovf = 0;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", valid, 1'b0);
    check("mid_rst_overflow", overflow, 1'b0);
    check("mid_rst_data", data, '0);
    check("mid_rst_last", last, 1'b0);
    check("mid_rst_almost_full", almost_full, 1'b0);
    ready_mode = 1;
    drive_frame(0);
    drain();
    check("frames_done_c", n_fd_seen, n_last_exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
